uart_word_rx: RTL and testbench
===============================

# uart_word_rx

Host-side receiver for the BIP accumulator dump link. It sits directly downstream of the serial interface's TX line and deserialises 8N1 UART frames. It pairs the bytes back into 16-bit accumulator words, low byte first and high byte second, and presents each word with a one-cycle valid strobe. It is used in system benches and loopback checks to recover what the BIP wrote.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Even, ≥4.
- TIMEOUT_BITS, 20: bit-times allowed between the high byte's start edge and the end of the low byte before the pending low byte is discarded.

Ports:
- CLK, input, 1: single clock, rising edge.
- RESET, input, 1: reset is asynchronous and active-low.
- RX, input, 1: serial line, idle high, asynchronous to CLK.
- DATA_OUT, output, 16: last assembled word as {high byte, low byte}.
- VALID, output, 1: one-cycle pulse when DATA_OUT updates.
- FRAME_ERR, output, 1: one-cycle pulse on a bad stop bit.
- SYNC_LOST, output, 1: one-cycle pulse when a pending low byte times out.
- BUSY, output, 1: high whenever the FSM is not in IDLE.

## Operation
- RX passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- The FSM has four states: IDLE, START, DATA and STOP.
  - IDLE: a 1→0 transition on rx_s loads the bit counter and moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If rx_s=0, go to DATA. If rx_s=1, the event is a glitch: return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register. Then go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample.
    - If rx_s=1, the byte is accepted. Return to IDLE.
    - If rx_s=0, pulse FRAME_ERR, discard the byte, and clear the pending phase (any stored low byte is dropped). Go to IDLE only after rx_s is seen high; line breaks are absorbed this way.
- Byte pairing uses a phase bit.
  - Phase 0: an accepted byte is stored as the low byte, phase becomes 1, and the timeout counter is cleared.
  - Phase 1: an accepted byte is the high byte. DATA_OUT ← {byte, low}, VALID pulses, and phase becomes 0.
- Timeout:
  - While phase=1 and the FSM is in IDLE, a counter advances once per cycle. It freezes in any other state.
  - When the counter reaches TIMEOUT_BITS*CLKS_PER_BIT, pulse SYNC_LOST and set phase to 0.
  - If the counter reaches its terminal value in the same cycle a start edge is detected, the timeout still applies. The incoming byte then becomes a new low byte.
- DATA_OUT holds its value between VALID pulses.

## Timing
- Reset (RESET=0, asynchronous): DATA_OUT=0x0000, VALID=0, FRAME_ERR=0, SYNC_LOST=0, BUSY=0, FSM=IDLE, phase=0, all counters 0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame immediately. After release, the block waits for a fresh falling edge.
- Let t0 be the cycle in which the falling edge is seen on rx_s. This is 2 cycles after the RX pin falls.
  - Start check at t0+CLKS_PER_BIT/2.
  - Data bit i sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
  - Stop bit sampled at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- VALID, FRAME_ERR and the DATA_OUT update occur in the cycle after the stop sample.
- Back-to-back frames with no idle time are supported. Any start edge seen while in IDLE after the stop sample is accepted.
- VALID, FRAME_ERR and SYNC_LOST are never high for more than one cycle. At most one of them is high in any cycle.
- Bits are not resynchronised within a frame. The block tolerates at least ±2% clock mismatch at CLKS_PER_BIT=16.

## Test plan
All scenarios use CLKS_PER_BIT=16 and TIMEOUT_BITS=20.
- Basic word: send 0x34 then 0x12, 8N1, with 2 idle bit-times between frames. Required: a single VALID pulse with DATA_OUT=0x1234, occurring 2+8+144+1 cycles after the second frame's start edge on the RX pin. BUSY is high during each frame.
- Glitch rejection: drive RX low for 4 cycles, then high. Required: no VALID and no FRAME_ERR, BUSY returns to 0 within 10 cycles, and a following 0xCD,0xAB pair yields 0xABCD.
- Framing error: send 0x77, then 0xAB with stop bit=0 held low for 3 bit-times, then 0x01 and 0x00. Required: FRAME_ERR pulses once, 0x77 is discarded, and the next VALID gives DATA_OUT=0x0001.
- Timeout: send 0x55, idle 400 cycles (more than 320), then send 0x78 and 0x56. Required: SYNC_LOST pulses 320 cycles after the 0x55 stop handling, with no VALID for 0x55, and then DATA_OUT=0x5678.
- Reset mid-operation: assert RESET during bit 3 of a high byte that follows a valid low byte. Required: all outputs are 0 while reset is asserted and phase is cleared. After release, 0x22,0x11 yields 0x1122.
- Streaming: send words 0x0000, 0xFFFF and 0xA55A back-to-back with no idle time. Required: exactly three VALID pulses, in that order, with the correct values.

Source files
------------

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that pairs bytes (low first, then high) into 16-bit words.
// A framing error or an inter-byte timeout discards a pending low byte.
module uart_word_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        RX,
   output logic [15:0] DATA_OUT,
   output logic        VALID,
   output logic        FRAME_ERR,
   output logic        SYNC_LOST,
   output logic        BUSY
);

   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int BW       = $clog2(CLKS_PER_BIT);
   localparam int TW       = $clog2(TO_LIMIT + 1);
   localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state, w_state_next;
   logic          r_rx_meta, r_rx_s, r_rx_prev;
   logic [BW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift, r_low;
   logic          r_brk, r_phase;
   logic [TW-1:0] r_to_cnt;
   logic [15:0]   r_data;
   logic          r_valid, r_ferr, r_sync;

   logic          w_fall, w_tick, w_load, w_sample, w_accept, w_ferr, w_to_fire;
   logic [BW-1:0] w_load_val;

   assign w_fall    = r_rx_prev & ~r_rx_s;
   assign w_tick    = (r_clk_cnt == '0);
   assign w_to_fire = r_phase && (r_state == S_IDLE) && (r_to_cnt == TO_LAST);

   // Synchroniser resets to the idle level so reset release never fakes a start edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking so each flop captures its predecessor's pre-edge value.
         r_rx_meta <= RX;
         r_rx_s    <= r_rx_meta;
         r_rx_prev <= r_rx_s;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_val   = FULL_M1;
      w_sample     = 1'b0;
      w_accept     = 1'b0;
      w_ferr       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_next = S_START;
               w_load       = 1'b1;
               w_load_val   = HALF_M1;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (r_rx_s) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_state_next = S_DATA;
                  w_load       = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_sample = 1'b1;
               w_load   = 1'b1;
               if (r_bit_idx == 3'd7) w_state_next = S_STOP;
            end
         end
         S_STOP: begin
            // After a bad stop bit, hold here until the line is released.
            if (r_brk) begin
               if (r_rx_s) w_state_next = S_IDLE;
            end else if (w_tick) begin
               if (r_rx_s) begin
                  w_accept     = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_ferr = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_low     <= '0;
         r_brk     <= 1'b0;
         r_phase   <= 1'b0;
         r_to_cnt  <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_sync    <= 1'b0;
      end else begin
         if (w_load)       r_clk_cnt <= w_load_val;
         else if (!w_tick) r_clk_cnt <= r_clk_cnt - 1'b1;

         if (r_state == S_IDLE) r_bit_idx <= '0;
         else if (w_sample)     r_bit_idx <= r_bit_idx + 1'b1;

         if (w_sample) r_shift <= {r_rx_s, r_shift[7:1]};

         r_brk <= (w_state_next == S_STOP) && (r_brk || w_ferr);

         if (w_ferr || w_to_fire) r_phase <= 1'b0;
         else if (w_accept)       r_phase <= ~r_phase;

         if (w_accept && !r_phase) r_low <= r_shift;

         // Idle time is only counted while a low byte waits for its partner.
         if ((w_accept && !r_phase) || w_to_fire)   r_to_cnt <= '0;
         else if (r_phase && (r_state == S_IDLE))   r_to_cnt <= r_to_cnt + 1'b1;

         r_valid <= w_accept && r_phase;
         if (w_accept && r_phase) r_data <= {r_shift, r_low};
         r_ferr  <= w_ferr;
         r_sync  <= w_to_fire;
      end
   end

   assign DATA_OUT  = r_data;
   assign VALID     = r_valid;
   assign FRAME_ERR = r_ferr;
   assign SYNC_LOST = r_sync;
   assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed + randomized bench for uart_word_rx; a timing-level byte/word model
// predicts every VALID, FRAME_ERR and SYNC_LOST pulse and its cycle.
module tb_uart_word_rx;

   localparam int C        = 16;
   localparam int TO_BITS  = 20;
   localparam int TO_LIMIT = C * TO_BITS;
   localparam int LAT      = 2 + C / 2 + 9 * C + 1;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } word_ev_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        RX = 1'b1;
   logic [15:0] DATA_OUT;
   logic        VALID, FRAME_ERR, SYNC_LOST, BUSY;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_strobe_bad = 0;
   logic r_prev_v = 1'b0, r_prev_f = 1'b0, r_prev_s = 1'b0;

   word_ev_t exp_words[$], obs_words[$];
   int       exp_ferr[$], obs_ferr[$], exp_sync[$], obs_sync[$];

   logic        m_phase = 1'b0;
   logic [7:0]  m_low   = '0;
   int          m_done  = 0;
   logic [15:0] m_last  = '0;

   uart_word_rx #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TO_BITS)) dut (
      .CLK(CLK), .RESET(RESET), .RX(RX), .DATA_OUT(DATA_OUT), .VALID(VALID),
      .FRAME_ERR(FRAME_ERR), .SYNC_LOST(SYNC_LOST), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (VALID)     obs_words.push_back('{cyc, DATA_OUT});
      if (FRAME_ERR) obs_ferr.push_back(cyc);
      if (SYNC_LOST) obs_sync.push_back(cyc);
      if ((int'(VALID) + int'(FRAME_ERR) + int'(SYNC_LOST)) > 1 ||
          (VALID && r_prev_v) || (FRAME_ERR && r_prev_f) || (SYNC_LOST && r_prev_s))
         n_strobe_bad <= n_strobe_bad + 1;
      r_prev_v <= VALID;
      r_prev_f <= FRAME_ERR;
      r_prev_s <= SYNC_LOST;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; holds RX for n full cycles and returns at posedge+1.
   task automatic drive_bit(input logic b, input int n);
      RX = b;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      if (n > 0) drive_bit(1'b1, n);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1,
                            input int stop_len = C, input bit chk_busy = 1'b0);
      int p;
      int v_cyc;
      p = cyc;
      // A pending low byte expires once TO_LIMIT idle cycles have elapsed, counting
      // up to and including the cycle the new start edge is seen (p+2).
      if (m_phase && (p + 3 >= m_done + TO_LIMIT)) begin
         exp_sync.push_back(m_done + TO_LIMIT);
         m_phase = 1'b0;
      end
      drive_bit(1'b0, C);
      if (chk_busy) check("busy_in_frame", BUSY, 1);
      for (int i = 0; i < 8; i++) drive_bit(b[i], C);
      drive_bit(stop_bit, stop_len);
      v_cyc = p + LAT;
      if (stop_bit) begin
         if (m_phase) begin
            m_last = {b, m_low};
            exp_words.push_back('{v_cyc, m_last});
            m_phase = 1'b0;
         end else begin
            m_low   = b;
            m_phase = 1'b1;
            m_done  = v_cyc;
         end
      end else begin
         exp_ferr.push_back(v_cyc);
         m_phase = 1'b0;
      end
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      send_byte(w[7:0]);
      idle(gap);
      send_byte(w[15:8]);
      idle(gap);
   endtask

   task automatic score(input string tag);
      word_ev_t o, e;
      check({tag, " n_valid"}, obs_words.size(), exp_words.size());
      while (obs_words.size() > 0 && exp_words.size() > 0) begin
         o = obs_words.pop_front();
         e = exp_words.pop_front();
         check({tag, " data"}, o.data, e.data);
         check({tag, " valid_cyc"}, o.cyc, e.cyc);
      end
      check({tag, " n_ferr"}, obs_ferr.size(), exp_ferr.size());
      while (obs_ferr.size() > 0 && exp_ferr.size() > 0)
         check({tag, " ferr_cyc"}, obs_ferr.pop_front(), exp_ferr.pop_front());
      check({tag, " n_sync"}, obs_sync.size(), exp_sync.size());
      while (obs_sync.size() > 0 && exp_sync.size() > 0)
         check({tag, " sync_cyc"}, obs_sync.pop_front(), exp_sync.pop_front());
      obs_words.delete(); exp_words.delete();
      obs_ferr.delete();  exp_ferr.delete();
      obs_sync.delete();  exp_sync.delete();
      check({tag, " strobe_rules"}, n_strobe_bad, 0);
      check({tag, " data_hold"}, DATA_OUT, m_last);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " data"},  DATA_OUT,  0);
      check({tag, " valid"}, VALID,     0);
      check({tag, " ferr"},  FRAME_ERR, 0);
      check({tag, " sync"},  SYNC_LOST, 0);
      check({tag, " busy"},  BUSY,      0);
   endtask

   initial begin
      logic [7:0] hb;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      RESET = 1'b1;
      idle(2 * C);

      // Basic word, two idle bit-times between bytes.
      send_byte(8'h34, 1'b1, C, 1'b1);
      idle(2 * C);
      send_byte(8'h12, 1'b1, C, 1'b1);
      idle(2 * C);
      check("busy_idle", BUSY, 0);
      score("basic");

      // Glitch rejection.
      RX = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      RX = 1'b1;
      check("glitch_busy", BUSY, 1);
      repeat (10) @(posedge CLK);
      #1;
      check("glitch_busy_clear", BUSY, 0);
      idle(2 * C);
      send_word(16'hABCD, 2 * C);
      score("glitch");

      // Framing error with a three-bit-time break.
      send_byte(8'h77);
      idle(2 * C);
      send_byte(8'hAB, 1'b0, 3 * C);
      idle(2 * C);
      send_word(16'h0001, 2 * C);
      score("frame_err");

      // Inter-byte timeout.
      send_byte(8'h55);
      idle(400);
      send_word(16'h5678, 2 * C);
      score("timeout");

      // Reset during bit 3 of a high byte.
      send_byte(8'h99);
      idle(2 * C);
      hb = 8'h5A;
      drive_bit(1'b0, C);
      for (int i = 0; i < 3; i++) drive_bit(hb[i], C);
      drive_bit(hb[3], C / 2);
      RESET = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      RX = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      m_phase = 1'b0;
      m_last  = '0;
      idle(2 * C);
      send_word(16'h1122, 2 * C);
      score("mid_reset_recover");

      // Back-to-back streaming.
      send_word(16'h0000, 0);
      send_word(16'hFFFF, 0);
      send_word(16'hA55A, 0);
      idle(2 * C);
      score("stream");

      // Random words with random short gaps.
      for (int k = 0; k < 6; k++) begin
         send_word(16'($urandom), int'($urandom_range(0, 3 * C)));
      end
      idle(2 * C);
      score("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
